program_loader: RTL and testbench

//  Writer side of the instruction memory. Accepts a byte stream (valid/ready),

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/program_loader_byte_packer.sv | 38 +++
 rtl/program_loader.sv | 113 +++++++++++
 tb/tb_program_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and word-format constants for the program loader
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE      = 2'(BYTES_PER_WORD - 1);
    localparam logic [31:0] TERMINATOR     = 32'h0;

endpackage

// File: rtl/program_loader_byte_packer.sv
// rtl/program_loader_byte_packer.sv - little-endian byte-to-word assembly with byte position counter
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_full,
    output logic [31:0] word_next
);

    logic [1:0]  byte_idx;
    logic [31:0] word;

    // Merge the incoming byte into the partial word so the full word is available on the 4th accept
    always_comb begin
        word_next = word;
        word_next[8*byte_idx +: 8] = data;
        word_full = accept && (byte_idx == LAST_BYTE);
    end

    // Byte position counter and assembly register; clear wins over a same-cycle accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            word     <= 32'h0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            word     <= 32'h0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= word_next;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams bytes into instruction memory words and holds the core until loaded
module program_loader
    import program_loader_pkg::*;
#(
    parameter int TAM    = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAM);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              start_ok;
    logic              packer_clear;
    logic              word_full;
    logic [31:0]       word_next;

    // in_ready is only high in COLLECT, so a handshake can only happen there
    always_comb begin
        accept       = in_valid && in_ready;
        start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
        packer_clear = start_ok || (state == ST_WRITE);
    end

    byte_packer u_packer (
        .clk       (clk),
        .rst       (reset),
        .clear     (packer_clear),
        .accept    (accept),
        .data      (in_data),
        .word_full (word_full),
        .word_next (word_next)
    );

    // Load sequencer: all outputs registered, mem_we raised on the edge that accepts the 4th byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_COLLECT;
                        in_ready   <= 1'b1;
                        word_idx   <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        state     <= ST_WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                        mem_wdata <= word_next;
                    end
                end
                ST_WRITE: begin
                    word_count <= word_count + ONE;
                    // A zero word terminates even when it lands in the last slot
                    if (mem_wdata == TERMINATOR) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        overflow <= 1'b0;
                    end else if (word_idx == LAST_IDX) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        state    <= ST_COLLECT;
                        in_ready <= 1'b1;
                        word_idx <= word_idx + ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven and randomized checks of program_loader against a word-level model
module tb_program_loader;

    localparam int TAM    = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [ADDR_W-1:0] word_count;
    logic              overflow;

    program_loader #(.TAM(TAM), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                nw;
        logic [0:5][31:0]  w;
        int                gap;
        int                mid;
        int                exp_count;
        bit                exp_ovf;
    } vec_t;

    vec_t        vt [6];
    logic [7:0]  tx_q [$];
    logic [63:0] wr_q [$];
    logic [63:0] exp_q [$];
    bit          exp_ovf;
    int          n_vec = 0;
    int          n_bad = 0;

    // Record every memory write strobe as {addr, data}
    always @(negedge clk) begin
        if (!reset && mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: word k is bytes 4k..4k+3 little-endian at address 4k; stop on zero word or full memory
    task automatic model();
        logic [31:0] wd;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int k = 0; 4*k + 3 < tx_q.size(); k++) begin
            wd = {tx_q[4*k+3], tx_q[4*k+2], tx_q[4*k+1], tx_q[4*k]};
            exp_q.push_back({32'(4*k), wd});
            if (wd == 32'h0) break;
            if (k == TAM) begin
                exp_ovf = 1'b1;
                break;
            end
        end
    endtask

    task automatic words_to_bytes(input int nw, input logic [0:5][31:0] w);
        tx_q.delete();
        for (int k = 0; k < nw; k++)
            for (int b = 0; b < 4; b++) tx_q.push_back(w[k][8*b +: 8]);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done_clr", {63'h0, done}, 64'h0);
        chk("start_hold_set", {63'h0, cpu_hold}, 64'h1);
    endtask

    task automatic drive(input int gap_pct, input int mid_start);
        int  i = 0;
        int  cyc = 0;
        bit  pulsed = 1'b0;
        while (i < tx_q.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) break;
            if (mid_start >= 0 && !pulsed && i == mid_start && in_ready) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = tx_q[i];
                if (in_ready) i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        if (cyc >= 2000) chk("drive_timeout", 64'(cyc), 64'(2000 - 1));
    endtask

    task automatic wait_done_and_check();
        int c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("done", {63'h0, done}, 64'h1);
        chk("cpu_hold_rel", {63'h0, cpu_hold}, 64'h0);
        chk("in_ready_idle", {63'h0, in_ready}, 64'h0);
        chk("n_writes", 64'(wr_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++)
            chk($sformatf("write%0d", k), wr_q[k], exp_q[k]);
        chk("word_count", 64'(word_count), 64'(exp_q.size()));
        chk("overflow", {63'h0, overflow}, {63'h0, exp_ovf});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{nw:2, w:{32'h13, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, gap:0, mid:-1, exp_count:2, exp_ovf:1'b0};
        vt[1] = '{nw:6, w:{32'h00100093, 32'h00100093, 32'h00100093, 32'h00100093, 32'h00100093, 32'h00100093},
                  gap:0, mid:-1, exp_count:5, exp_ovf:1'b1};
        vt[2] = '{nw:2, w:{32'h13, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, gap:50, mid:-1, exp_count:2, exp_ovf:1'b0};
        vt[3] = '{nw:5, w:{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0}, gap:10, mid:-1, exp_count:5, exp_ovf:1'b0};
        vt[4] = '{nw:1, w:{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, gap:0, mid:-1, exp_count:1, exp_ovf:1'b0};
        vt[5] = '{nw:2, w:{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, gap:20, mid:2, exp_count:2, exp_ovf:1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rst_cpu_hold", {63'h0, cpu_hold}, 64'h1);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_word_count", 64'(word_count), 64'h0);
        chk("rst_overflow", {63'h0, overflow}, 64'h0);
        reset = 1'b0;

        // Directed table; loads after the first begin from DONE
        for (int v = 0; v < 6; v++) begin
            words_to_bytes(vt[v].nw, vt[v].w);
            model();
            wr_q.delete();
            do_start();
            drive(vt[v].gap, vt[v].mid);
            wait_done_and_check();
            chk($sformatf("tbl%0d_count", v), 64'(word_count), 64'(vt[v].exp_count));
            chk($sformatf("tbl%0d_ovf", v), {63'h0, overflow}, {63'h0, vt[v].exp_ovf});
        end

        // Asynchronous reset in the middle of the second word
        begin
            logic [0:5][31:0] w;
            w = {32'h55667788, 32'h99AABBCC, 32'h0, 32'h0, 32'h0, 32'h0};
            words_to_bytes(2, w);
            void'(tx_q.pop_back());
            void'(tx_q.pop_back());
            do_start();
            drive(0, -1);
            reset = 1'b1;
            #1;
            chk("mid_rst_cpu_hold", {63'h0, cpu_hold}, 64'h1);
            chk("mid_rst_mem_we", {63'h0, mem_we}, 64'h0);
            chk("mid_rst_mem_addr", 64'(mem_addr), 64'h0);
            chk("mid_rst_word_count", 64'(word_count), 64'h0);
            chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h0);
            @(negedge clk);
            reset = 1'b0;
            words_to_bytes(vt[0].nw, vt[0].w);
            model();
            wr_q.delete();
            do_start();
            drive(0, -1);
            wait_done_and_check();
        end

        // Randomized programs with random handshake gaps
        for (int r = 0; r < 10; r++) begin
            int nw;
            logic [31:0] wd;
            nw = int'($urandom_range(0, 6));
            tx_q.delete();
            for (int k = 0; k < nw; k++) begin
                wd = $urandom;
                if (wd == 32'h0) wd = 32'h1;
                for (int b = 0; b < 4; b++) tx_q.push_back(wd[8*b +: 8]);
            end
            for (int b = 0; b < 4; b++) tx_q.push_back(8'h0);
            model();
            wr_q.delete();
            do_start();
            drive(int'($urandom_range(0, 60)), -1);
            wait_done_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
